adder_round_sched: RTL and testbench
====================================

Name: adder_round_sched

Overview:
- Sequences the partial-sum adder tree for one convolution job at a time.
- Accepts a job descriptor (kernel size, stride) from the layer controller.
- Gates multiplier-result beats into the adder, driving wsize/stride/wround/MUL_DATA_valid so each kernel size gets the correct number of weight rounds.
- Waits for the adder's Psum_valid, then reports job completion. MUL_results data bypasses this block; only control passes through it.

Parameters:
- WSIZE_W, 4, width of the wsize field (0=3x3, 1=5x5, 2=7x7, others illegal).
- WROUND_W, 3, width of the wround output.
- DRAIN_TIMEOUT, 64, DRAIN cycles before timeout; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  block can accept a job.
- job_wsize  in  WSIZE_W  kernel size code.
- job_stride  in  1  0=stride 1, 1=stride 2.
- mul_valid  in  1  multiplier result for the current round is available.
- mul_ready  out  1  block will consume the current round beat.
- adder_wsize  out  WSIZE_W  to ADDER wsize.
- adder_stride  out  1  to ADDER stride.
- adder_wround  out  WROUND_W  to ADDER wround.
- adder_data_valid  out  1  to ADDER MUL_DATA_valid.
- psum_valid  in  1  from ADDER Psum_valid.
- job_done  out  1  one-cycle completion pulse.
- err_wsize  out  1  one-cycle pulse; illegal wsize was accepted.
- err_timeout  out  1  one-cycle pulse; drain timeout (optional feature).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: state=IDLE, round counter=0. adder_wsize=0, adder_stride=0, adder_wround=0, adder_data_valid=0, mul_ready=0, job_done=0, err_wsize=0, err_timeout=0, busy=0. job_ready=1 in the cycle after reset deasserts.
- Reset mid-job: state returns to IDLE on the next edge. The in-flight job is dropped; no job_done is issued.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - job_ready=1.
  - On job_valid&job_ready, register job_wsize/job_stride into adder_wsize/adder_stride and clear the round counter.
  - Legal wsize: go to ISSUE.
  - Illegal wsize (>2): go to DONE with err_wsize asserted in DONE. No beats are issued.
- Round count N, fixed at accept:
  - wsize0: N=1 (either stride).
  - wsize1: N=2 at stride 1, N=1 at stride 2.
  - wsize2: N=4 at stride 1, N=2 at stride 2.
- ISSUE:
  - mul_ready=1.
  - adder_data_valid = mul_valid & mul_ready (combinational).
  - adder_wround = round counter (registered).
  - On a handshake the counter increments. The handshake with counter==N-1 moves to DRAIN and the counter returns to 0.
  - mul_valid low stalls the round: counter and wround hold, and adder_data_valid=0.
- DRAIN:
  - mul_ready=0, adder_data_valid=0.
  - On psum_valid, go to DONE.
  - psum_valid is sampled only in DRAIN and ignored in every other state.
- DONE:
  - job_done=1 for exactly one cycle, then IDLE.
  - job_ready is low in DONE, so back-to-back jobs have a minimum 1-cycle gap after DONE.
- adder_wsize/adder_stride hold their values from accept until the next accept, including while in IDLE.
- Latency:
  - Accept at cycle T; first possible beat at T+1.
  - Last beat at R; DRAIN at R+1.
  - psum_valid at P (P≥R+1); job_done at P+1; job_ready at P+2.
- Simultaneous events:
  - job_valid outside IDLE is not accepted; the requester holds it.
  - rst dominates all other inputs.

Optional Feature:
- Macro: ADDER_ROUND_SCHED_TIMEOUT_EN.
- Defined: a counter clears on DRAIN entry and increments each DRAIN cycle without psum_valid. When it reaches DRAIN_TIMEOUT, go to DONE with err_timeout=1 and job_done=1 in the same cycle. psum_valid arriving on the expiry cycle wins, and no error is raised.
- Undefined: DRAIN waits indefinitely; err_timeout is tied to 0 and no counter exists.

Test Plan:
- wsize=0, stride=0, mul_valid held high → one beat with wround=0; psum_valid 2 cycles later → job_done exactly 1 cycle later; busy=1 from accept until DONE.
- wsize=1, stride=0, mul_valid high → beats wround 0,1 on consecutive cycles; then wsize=2, stride=0 → beats wround 0,1,2,3. Each job ends with one job_done after its psum_valid.
- wsize=2, stride=1 → exactly 2 beats, wround 0,1; wsize=1, stride=1 → exactly 1 beat, wround 0.
- wsize=2, stride=0 with mul_valid pattern 1,0,0,1,1,0,1 → adder_data_valid only on mul_valid=1 cycles. wround 0,1,2,3 advances only on handshakes.
- wsize=5 → err_wsize and job_done pulse together one cycle after accept, adder_data_valid never asserts; rst raised during ISSUE of a wsize=2 job after wround=1 → next cycle IDLE, all outputs at reset values, no job_done.
- With ADDER_ROUND_SCHED_TIMEOUT_EN, DRAIN_TIMEOUT=8, psum_valid never asserted → err_timeout=1 and job_done=1 on DRAIN cycle 8, then IDLE. Without the macro, the block stays in DRAIN with busy=1 for 100 cycles.

Source files
------------

// File: rtl/adder_round_sched.sv
// Round scheduler for the partial-sum adder: one job at a time, gates multiplier beats.
// Optional drain watchdog enabled by ADDER_ROUND_SCHED_TIMEOUT_EN.
module adder_round_sched #(
    parameter int WSIZE_W       = 4,
    parameter int WROUND_W      = 3,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [WSIZE_W-1:0]  job_wsize,
    input  logic                job_stride,
    input  logic                mul_valid,
    output logic                mul_ready,
    output logic [WSIZE_W-1:0]  adder_wsize,
    output logic                adder_stride,
    output logic [WROUND_W-1:0] adder_wround,
    output logic                adder_data_valid,
    input  logic                psum_valid,
    output logic                job_done,
    output logic                err_wsize,
    output logic                err_timeout,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WROUND_W-1:0] round_q;
    logic [WROUND_W-1:0] last_q;
    logic [WROUND_W-1:0] last_d;
    logic                legal;
    logic                bad_q;
    logic                accept;
    logic                beat;
    logic                last_beat;
    logic                expire;

    assign accept    = job_valid & job_ready;
    assign beat      = mul_valid & mul_ready;
    assign last_beat = beat & (round_q == last_q);

    // Last round index, latched at accept so the job cannot change mid-flight.
    always_comb begin
        last_d = '0;
        legal  = 1'b1;
        case (job_wsize)
            WSIZE_W'(0): last_d = '0;
            WSIZE_W'(1): last_d = job_stride ? WROUND_W'(0) : WROUND_W'(1);
            WSIZE_W'(2): last_d = job_stride ? WROUND_W'(1) : WROUND_W'(3);
            default:     legal  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = legal ? ISSUE : DONE;
            end
            ISSUE: begin
                if (last_beat) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (psum_valid || expire) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_q      <= '0;
            last_q       <= '0;
            bad_q        <= 1'b0;
            adder_wsize  <= '0;
            adder_stride <= 1'b0;
        end else if (accept) begin
            round_q      <= '0;
            last_q       <= last_d;
            bad_q        <= ~legal;
            adder_wsize  <= job_wsize;
            adder_stride <= job_stride;
        end else if (beat) begin
            round_q <= last_beat ? '0 : round_q + WROUND_W'(1);
        end
    end

`ifdef ADDER_ROUND_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    logic [TW-1:0] drain_cnt;
    logic          to_q;

    // Psum arriving on the expiry cycle takes priority over the timeout.
    assign expire = (state == DRAIN) & ~psum_valid
                  & (drain_cnt == TW'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != DRAIN) begin
            drain_cnt <= '0;
        end else if (!psum_valid) begin
            drain_cnt <= drain_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_q <= 1'b0;
        end else begin
            to_q <= expire;
        end
    end

    assign err_timeout = (state == DONE) & to_q;
`else
    logic unused_timeout;

    assign unused_timeout = (DRAIN_TIMEOUT > 0);
    assign expire         = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    always_comb begin
        job_ready        = (state == IDLE) & ~rst;
        mul_ready        = (state == ISSUE);
        adder_data_valid = beat;
        adder_wround     = round_q;
        job_done         = (state == DONE);
        err_wsize        = (state == DONE) & bad_q;
        busy             = (state != IDLE);
    end

endmodule

// File: tb/tb_adder_round_sched.sv
// Directed bench for adder_round_sched with a beat/done scoreboard.
module tb_adder_round_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       job_valid;
    logic       job_ready;
    logic [3:0] job_wsize;
    logic       job_stride;
    logic       mul_valid;
    logic       mul_ready;
    logic [3:0] adder_wsize;
    logic       adder_stride;
    logic [2:0] adder_wround;
    logic       adder_data_valid;
    logic       psum_valid;
    logic       job_done;
    logic       err_wsize;
    logic       err_timeout;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int beat_q[$];
    logic [1:0] done_q[$];

    always #5 clk = ~clk;

    adder_round_sched #(
        .WSIZE_W(4),
        .WROUND_W(3),
        .DRAIN_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_wsize(job_wsize),
        .job_stride(job_stride),
        .mul_valid(mul_valid),
        .mul_ready(mul_ready),
        .adder_wsize(adder_wsize),
        .adder_stride(adder_stride),
        .adder_wround(adder_wround),
        .adder_data_valid(adder_data_valid),
        .psum_valid(psum_valid),
        .job_done(job_done),
        .err_wsize(err_wsize),
        .err_timeout(err_timeout),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rounds(input logic [3:0] ws, input logic st);
        case (ws)
            4'd0:    return 1;
            4'd1:    return st ? 1 : 2;
            4'd2:    return st ? 2 : 4;
            default: return 0;
        endcase
    endfunction

    // Scoreboard: every beat and every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (adder_data_valid === 1'b1) begin
                chk("beat_expected", beat_q.size() != 0, 1);
                chk("beat_mul_valid", mul_valid, 1);
                if (beat_q.size() != 0) chk("wround", adder_wround, beat_q.pop_front());
            end
            if (job_done === 1'b1) begin
                chk("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0)
                    chk("done_errs", {err_timeout, err_wsize}, done_q.pop_front());
            end
        end
    end

    task automatic run_job(input logic [3:0] ws, input logic st,
                           input logic [15:0] pat, input int plen, input int pdly);
        int n;
        int i;
        bit brk;
        n = rounds(ws, st);
        for (int k = 0; k < n; k++) beat_q.push_back(k);
        done_q.push_back({1'b0, ws > 4'd2});
        @(posedge clk); #1;
        job_wsize  = ws;
        job_stride = st;
        job_valid  = 1'b1;
        @(negedge clk);
        chk("job_ready_idle", job_ready, 1);
        @(posedge clk); #1;
        job_valid = 1'b0;
        if (ws > 4'd2) begin
            mul_valid = 1'b1;
            @(negedge clk);
            chk("bad_done", job_done, 1);
            chk("bad_err", err_wsize, 1);
            chk("bad_no_beat", adder_data_valid, 0);
            @(posedge clk); #1;
            mul_valid = 1'b0;
            @(negedge clk);
            chk("bad_idle", job_ready, 1);
        end else begin
            i   = 0;
            brk = 1'b0;
            while (!brk && i < 64) begin
                mul_valid  = pat[i % plen];
                psum_valid = ~mul_valid;
                @(negedge clk);
                if (mul_ready !== 1'b1) begin
                    brk        = 1'b1;
                    psum_valid = 1'b0;
                    mul_valid  = 1'b0;
                end else begin
                    chk("dv_follows_mv", adder_data_valid, mul_valid);
                    chk("busy_issue", busy, 1);
                    @(posedge clk); #1;
                    i++;
                end
            end
            chk("reached_drain", brk, 1);
            chk("drain_dv", adder_data_valid, 0);
            chk("drain_busy", busy, 1);
            chk("drain_wsize", adder_wsize, ws);
            chk("drain_stride", adder_stride, st);
            for (int d = 0; d < pdly; d++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("drain_no_done", job_done, 0);
            end
            @(posedge clk); #1;
            psum_valid = 1'b1;
            @(posedge clk); #1;
            psum_valid = 1'b0;
            @(negedge clk);
            chk("done_pulse", job_done, 1);
            chk("done_busy", busy, 1);
            chk("done_not_ready", job_ready, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("after_ready", job_ready, 1);
            chk("after_done_low", job_done, 0);
            chk("after_busy", busy, 0);
            chk("hold_wsize", adder_wsize, ws);
        end
        chk("beats_drained", beat_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_wsize  = '0;
        job_stride = 1'b0;
        mul_valid  = 1'b0;
        psum_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wsize", adder_wsize, 0);
        chk("rst_stride", adder_stride, 0);
        chk("rst_wround", adder_wround, 0);
        chk("rst_dv", adder_data_valid, 0);
        chk("rst_mul_ready", mul_ready, 0);
        chk("rst_done", job_done, 0);
        chk("rst_err_wsize", err_wsize, 0);
        chk("rst_err_to", err_timeout, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", job_ready, 1);

        run_job(4'd0, 1'b0, 16'hFFFF, 1, 2);
        run_job(4'd1, 1'b0, 16'hFFFF, 1, 0);
        run_job(4'd2, 1'b0, 16'hFFFF, 1, 1);
        run_job(4'd2, 1'b1, 16'hFFFF, 1, 0);
        run_job(4'd1, 1'b1, 16'hFFFF, 1, 3);
        run_job(4'd2, 1'b0, 16'h0059, 7, 0);
        run_job(4'd5, 1'b0, 16'hFFFF, 1, 0);

        // Reset in the middle of a 7x7 job after round 1 was issued.
        @(posedge clk); #1;
        beat_q.push_back(0);
        beat_q.push_back(1);
        job_wsize  = 4'd2;
        job_stride = 1'b0;
        job_valid  = 1'b1;
        mul_valid  = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b1;
        mul_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", job_ready, 1);
        chk("mid_rst_wsize", adder_wsize, 0);
        chk("mid_rst_wround", adder_wround, 0);
        chk("mid_rst_mul_ready", mul_ready, 0);
        chk("mid_rst_done", job_done, 0);
        chk("mid_rst_beats", beat_q.size(), 0);
        repeat (4) begin
            @(negedge clk);
            chk("mid_rst_no_done", job_done, 0);
        end

        // Drain without psum_valid.
        @(posedge clk); #1;
        beat_q.push_back(0);
        job_wsize  = 4'd0;
        job_stride = 1'b0;
        job_valid  = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        mul_valid = 1'b1;
        @(posedge clk); #1;
        mul_valid = 1'b0;
`ifdef ADDER_ROUND_SCHED_TIMEOUT_EN
        done_q.push_back(2'b10);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("to_wait_done", job_done, 0);
            chk("to_wait_busy", busy, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_done", job_done, 1);
        chk("to_err", err_timeout, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_idle", busy, 0);
`else
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("hang_busy", busy, 1);
            chk("hang_no_done", job_done, 0);
            chk("hang_no_err", err_timeout, 0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("hang_rst_idle", busy, 0);
`endif
        chk("final_beats", beat_q.size(), 0);
        chk("final_dones", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
